// File: rtl/pic10_pkg.sv
// +----------------------------------------------------------------------------+
// | pic10_pkg: shared types and constants for the PIC10 instruction sequencer  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package pic10_pkg;

    typedef enum logic [1:0] {
        ST_EXEC  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_SLEEP = 2'd2,
        ST_TRAP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SKIP_NONE = 2'd0,
        SKIP_Z    = 2'd1,
        SKIP_NZ   = 2'd2
    } skip_e;

    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q2 = 2'd1;
    localparam logic [1:0] Q3 = 2'd2;
    localparam logic [1:0] Q4 = 2'd3;

    localparam logic [1:0] MUX_FILE = 2'd0;
    localparam logic [1:0] MUX_LIT  = 2'd1;
    localparam logic [1:0] MUX_BIT  = 2'd2;

    // Byte-oriented opcodes, ir[11:6]
    localparam logic [5:0] OP_SUBWF  = 6'b000010;
    localparam logic [5:0] OP_DECFSZ = 6'b001011;
    localparam logic [5:0] OP_SWAPF  = 6'b001110;
    localparam logic [5:0] OP_INCFSZ = 6'b001111;

    // Bit, literal and control opcodes, ir[11:8]
    localparam logic [3:0] OP_BCF   = 4'b0100;
    localparam logic [3:0] OP_BSF   = 4'b0101;
    localparam logic [3:0] OP_BTFSC = 4'b0110;
    localparam logic [3:0] OP_BTFSS = 4'b0111;
    localparam logic [3:0] OP_RETLW = 4'b1000;
    localparam logic [3:0] OP_CALL  = 4'b1001;
    localparam logic [3:0] OP_GOTOA = 4'b1010;
    localparam logic [3:0] OP_GOTOB = 4'b1011;
    localparam logic [3:0] OP_MOVLW = 4'b1100;
    localparam logic [3:0] OP_IORLW = 4'b1101;
    localparam logic [3:0] OP_ANDLW = 4'b1110;
    localparam logic [3:0] OP_XORLW = 4'b1111;

    // Miscellaneous ops, ir[4:0] when ir[11:5] == 0
    localparam logic [4:0] MISC_NOP    = 5'h00;
    localparam logic [4:0] MISC_OPTION = 5'h02;
    localparam logic [4:0] MISC_SLEEP  = 5'h03;
    localparam logic [4:0] MISC_CLRWDT = 5'h04;
    localparam logic [4:0] MISC_TRIS   = 5'h06;

    function automatic logic byte_op_sets_status(input logic [5:0] op);
        logic r;
        case (op)
            OP_DECFSZ, OP_INCFSZ, OP_SWAPF: r = 1'b0;
            default:                        r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pic10_decode.sv
// +----------------------------------------------------------------------------+
// | pic10_decode: combinational instruction decoder for the PIC10 sequencer    |
// | Illegal-opcode flag exists only with PIC10_CTRL_ILLEGAL_TRAP_EN.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module pic10_decode
    import pic10_pkg::*;
(
`ifdef PIC10_CTRL_ILLEGAL_TRAP_EN
    output logic        illegal_o,
`endif
    input  logic [11:0] ir_i,
    output logic [1:0]  alu_mux_sel_o,
    output logic        w_wr_o,
    output logic        f_wr_o,
    output logic        st_wr_o,
    output logic        is_goto_o,
    output logic        is_call_o,
    output logic        is_retlw_o,
    output skip_e       skip_type_o,
    output logic        is_sleep_o
);

    logic [5:0] w_op6;
    assign w_op6 = ir_i[11:6];

    always_comb begin
        alu_mux_sel_o = MUX_FILE;
        w_wr_o        = 1'b0;
        f_wr_o        = 1'b0;
        st_wr_o       = 1'b0;
        is_goto_o     = 1'b0;
        is_call_o     = 1'b0;
        is_retlw_o    = 1'b0;
        skip_type_o   = SKIP_NONE;
        is_sleep_o    = 1'b0;
`ifdef PIC10_CTRL_ILLEGAL_TRAP_EN
        illegal_o     = 1'b0;
`endif
        if (ir_i[11:10] == 2'b00) begin
            if (w_op6 >= OP_SUBWF) begin
                // Byte-oriented ops: d selects the destination
                w_wr_o  = ~ir_i[5];
                f_wr_o  = ir_i[5];
                st_wr_o = byte_op_sets_status(w_op6);
                if (w_op6 == OP_DECFSZ || w_op6 == OP_INCFSZ) begin
                    skip_type_o = SKIP_Z;
                end
            end else if (w_op6 == 6'b000001) begin
                st_wr_o = 1'b1;
                if (ir_i[5]) begin
                    f_wr_o = 1'b1;
                end else begin
                    w_wr_o = 1'b1;
                end
            end else if (ir_i[5]) begin
                f_wr_o = 1'b1;
            end else begin
                case (ir_i[4:0])
                    MISC_NOP, MISC_OPTION, MISC_CLRWDT, MISC_TRIS: begin
                    end
                    MISC_SLEEP: is_sleep_o = 1'b1;
                    default: begin
`ifdef PIC10_CTRL_ILLEGAL_TRAP_EN
                        illegal_o = 1'b1;
`endif
                    end
                endcase
            end
        end else begin
            case (ir_i[11:8])
                OP_BCF, OP_BSF: begin
                    alu_mux_sel_o = MUX_BIT;
                    f_wr_o        = 1'b1;
                end
                OP_BTFSC: begin
                    alu_mux_sel_o = MUX_BIT;
                    skip_type_o   = SKIP_Z;
                end
                OP_BTFSS: begin
                    alu_mux_sel_o = MUX_BIT;
                    skip_type_o   = SKIP_NZ;
                end
                OP_RETLW: begin
                    alu_mux_sel_o = MUX_LIT;
                    w_wr_o        = 1'b1;
                    is_retlw_o    = 1'b1;
                end
                OP_CALL:           is_call_o = 1'b1;
                OP_GOTOA, OP_GOTOB: is_goto_o = 1'b1;
                OP_MOVLW: begin
                    alu_mux_sel_o = MUX_LIT;
                    w_wr_o        = 1'b1;
                end
                OP_IORLW, OP_ANDLW, OP_XORLW: begin
                    alu_mux_sel_o = MUX_LIT;
                    w_wr_o        = 1'b1;
                    st_wr_o       = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pic10_control.sv
// +----------------------------------------------------------------------------+
// | pic10_control: Q-cycle sequencer, IR and strobe generation for PIC10 core  |
// | Optional macro PIC10_CTRL_ILLEGAL_TRAP_EN adds TRAP state and illegal_op.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module pic10_control
    import pic10_pkg::*;
#(
    parameter bit RESET_FLUSH = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] prog_data,
    input  logic        alu_zero,
    input  logic        wake,
    output logic [11:0] ir_reg_bus,
    output logic [1:0]  q_phase,
    output logic [1:0]  alu_mux_sel,
    output logic        w_we,
    output logic        f_we,
    output logic        status_we,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        stack_push,
    output logic        stack_pop,
`ifdef PIC10_CTRL_ILLEGAL_TRAP_EN
    output logic        illegal_op,
`endif
    output logic        sleeping
);

    state_e      state_q, state_d, exec_next;
    logic [1:0]  phase_q, phase_d;
    logic [11:0] ir_q, ir_d;
    logic [1:0]  mux_q, mux_d;
    logic        w_we_q, w_we_d, f_we_q, f_we_d, st_we_q, st_we_d;
    logic        inc_q, inc_d, load_q, load_d, push_q, push_d, pop_q, pop_d;

    logic [1:0]  dec_mux;
    logic        dec_w, dec_f, dec_st, dec_goto, dec_call, dec_retlw, dec_sleep;
    skip_e       dec_skip;
    logic        skip_taken, exec_q3, run_d;
`ifdef PIC10_CTRL_ILLEGAL_TRAP_EN
    logic        dec_illegal;
`endif

    pic10_decode u_decode (
`ifdef PIC10_CTRL_ILLEGAL_TRAP_EN
        .illegal_o     (dec_illegal),
`endif
        .ir_i          (ir_q),
        .alu_mux_sel_o (dec_mux),
        .w_wr_o        (dec_w),
        .f_wr_o        (dec_f),
        .st_wr_o       (dec_st),
        .is_goto_o     (dec_goto),
        .is_call_o     (dec_call),
        .is_retlw_o    (dec_retlw),
        .skip_type_o   (dec_skip),
        .is_sleep_o    (dec_sleep)
    );

    assign skip_taken = ((dec_skip == SKIP_Z)  &&  alu_zero) ||
                        ((dec_skip == SKIP_NZ) && !alu_zero);

    always_comb begin
        exec_next = ST_EXEC;
        if (dec_sleep) begin
            exec_next = ST_SLEEP;
        end else if (dec_goto || dec_call || dec_retlw || skip_taken) begin
            exec_next = ST_FLUSH;
        end
`ifdef PIC10_CTRL_ILLEGAL_TRAP_EN
        if (dec_illegal) begin
            exec_next = ST_TRAP;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 2'd1;
        case (state_q)
            ST_EXEC: begin
                if (phase_q == Q4) begin
                    state_d = exec_next;
                end
            end
            ST_FLUSH: begin
                if (phase_q == Q4) begin
                    state_d = ST_EXEC;
                end
            end
            ST_SLEEP: begin
                // Waking resumes mid-cycle at Q2 of a flush cycle
                phase_d = Q1;
                if (wake) begin
                    state_d = ST_FLUSH;
                    phase_d = Q2;
                end
            end
            default: phase_d = Q1;
        endcase
    end

    // Strobes are registered, so each is computed for the phase being entered
    always_comb begin
        exec_q3 = (state_q == ST_EXEC) && (phase_q == Q3);
        run_d   = (state_d == ST_EXEC) || (state_d == ST_FLUSH);
        w_we_d  = exec_q3 && dec_w;
        f_we_d  = exec_q3 && dec_f;
        st_we_d = exec_q3 && dec_st;
        load_d  = exec_q3 && (dec_goto || dec_call || dec_retlw);
        push_d  = exec_q3 && dec_call;
        pop_d   = exec_q3 && dec_retlw;
        inc_d   = run_d && (phase_d == Q1);
        mux_d   = (run_d && (phase_d != Q1)) ? dec_mux : MUX_FILE;
        ir_d    = ir_q;
        if ((phase_q == Q4) && ((state_q == ST_EXEC) || (state_q == ST_FLUSH))) begin
            ir_d = prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_FLUSH ? ST_FLUSH : ST_EXEC;
            phase_q <= Q1;
            ir_q    <= 12'h000;
            mux_q   <= MUX_FILE;
            w_we_q  <= 1'b0;
            f_we_q  <= 1'b0;
            st_we_q <= 1'b0;
            inc_q   <= 1'b0;
            load_q  <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ir_q    <= ir_d;
            mux_q   <= mux_d;
            w_we_q  <= w_we_d;
            f_we_q  <= f_we_d;
            st_we_q <= st_we_d;
            inc_q   <= inc_d;
            load_q  <= load_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
        end
    end

    assign ir_reg_bus  = ir_q;
    assign q_phase     = phase_q;
    assign alu_mux_sel = mux_q;
    assign w_we        = w_we_q;
    assign f_we        = f_we_q;
    assign status_we   = st_we_q;
    assign pc_inc      = inc_q;
    assign pc_load     = load_q;
    assign stack_push  = push_q;
    assign stack_pop   = pop_q;
    assign sleeping    = (state_q == ST_SLEEP);
`ifdef PIC10_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op  = (state_q == ST_TRAP);
`endif

endmodule

`default_nettype wire

// File: tb/tb_pic10_control.sv
// +----------------------------------------------------------------------------+
// | tb_pic10_control: directed self-checking bench for pic10_control           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pic10_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] prog_data = 12'h000;
    logic        alu_zero = 1'b0;
    logic        wake = 1'b0;
    logic [11:0] ir_reg_bus;
    logic [1:0]  q_phase;
    logic [1:0]  alu_mux_sel;
    logic        w_we, f_we, status_we, pc_inc, pc_load, stack_push, stack_pop;
    logic        sleeping;

    int checks = 0;
    int failures = 0;

    pic10_control #(.RESET_FLUSH(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_data   (prog_data),
        .alu_zero    (alu_zero),
        .wake        (wake),
        .ir_reg_bus  (ir_reg_bus),
        .q_phase     (q_phase),
        .alu_mux_sel (alu_mux_sel),
        .w_we        (w_we),
        .f_we        (f_we),
        .status_we   (status_we),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .stack_push  (stack_push),
        .stack_pop   (stack_pop),
        .sleeping    (sleeping)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {w_we, f_we, status_we, pc_inc, pc_load, stack_push, stack_pop}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_INC  = 7'b0001000;

    typedef struct packed {
        logic [11:0] prog;
        logic        z;
        logic [6:0]  e1;
        logic [1:0]  em;
        logic [6:0]  e4;
    } row_t;

    row_t rows [18];

    function automatic logic [6:0] strb();
        return {w_we, f_we, status_we, pc_inc, pc_load, stack_push, stack_pop};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction cycle from Q1; prog is the word fetched at its end
    task automatic run_row(input int idx, input row_t r);
        prog_data = r.prog;
        alu_zero  = r.z;
        check($sformatf("r%0d_q1_phase", idx), {30'd0, q_phase}, 32'd0);
        check($sformatf("r%0d_q1_strobes", idx), {25'd0, strb()}, {25'd0, r.e1});
        step();
        check($sformatf("r%0d_q2_mux", idx), {30'd0, alu_mux_sel}, {30'd0, r.em});
        step();
        step();
        check($sformatf("r%0d_q4_strobes", idx), {25'd0, strb()}, {25'd0, r.e4});
        step();
        check($sformatf("r%0d_ir", idx), {20'd0, ir_reg_bus}, {20'd0, r.prog});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=%0d exp=finish", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rows[0]  = '{12'h1C0, 1'b0, S_NONE, 2'd0, S_NONE};       // reset flush
        rows[1]  = '{12'h1E5, 1'b0, S_INC,  2'd0, 7'b1010000};   // ADDWF d=0
        rows[2]  = '{12'hA10, 1'b0, S_INC,  2'd0, 7'b0110000};   // ADDWF d=1
        rows[3]  = '{12'h1E5, 1'b0, S_INC,  2'd0, 7'b0000100};   // GOTO
        rows[4]  = '{12'h2C3, 1'b0, S_INC,  2'd0, S_NONE};       // flush
        rows[5]  = '{12'h1E5, 1'b1, S_INC,  2'd0, 7'b1000000};   // DECFSZ, zero
        rows[6]  = '{12'h2C3, 1'b0, S_INC,  2'd0, S_NONE};       // flush
        rows[7]  = '{12'h1E5, 1'b0, S_INC,  2'd0, 7'b1000000};   // DECFSZ, nonzero
        rows[8]  = '{12'hC55, 1'b0, S_INC,  2'd0, 7'b0110000};   // ADDWF, no flush
        rows[9]  = '{12'h5A5, 1'b0, S_INC,  2'd1, 7'b1000000};   // MOVLW
        rows[10] = '{12'h7A5, 1'b0, S_INC,  2'd2, 7'b0100000};   // BSF
        rows[11] = '{12'h1E5, 1'b0, S_INC,  2'd2, S_NONE};       // BTFSS, skip
        rows[12] = '{12'h905, 1'b0, S_INC,  2'd0, S_NONE};       // flush
        rows[13] = '{12'h1E5, 1'b0, S_INC,  2'd0, 7'b0000110};   // CALL
        rows[14] = '{12'h8AA, 1'b0, S_INC,  2'd0, S_NONE};       // flush
        rows[15] = '{12'h1E5, 1'b0, S_INC,  2'd1, 7'b1000101};   // RETLW
        rows[16] = '{12'h003, 1'b0, S_INC,  2'd0, S_NONE};       // flush
        rows[17] = '{12'h1E5, 1'b0, S_INC,  2'd0, S_NONE};       // SLEEP

        prog_data = 12'h1C0;
        step();
        step();
        check("rst_ir", {20'd0, ir_reg_bus}, 32'd0);
        check("rst_phase", {30'd0, q_phase}, 32'd0);
        check("rst_strobes", {25'd0, strb()}, 32'd0);
        check("rst_mux_sleep", {29'd0, alu_mux_sel, sleeping}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_row(i, rows[i]);
        end

        for (int i = 0; i < 20; i++) begin
            check($sformatf("sleep_hold%0d", i), {22'd0, sleeping, q_phase, strb()},
                  {22'd0, 1'b1, 2'd0, S_NONE});
            step();
        end

        prog_data = 12'h1C0;
        wake = 1'b1;
        step();
        wake = 1'b0;
        check("wake_phase_sleep", {29'd0, sleeping, q_phase}, {29'd0, 1'b0, 2'd1});
        check("wake_strobes", {25'd0, strb()}, 32'd0);
        step();
        step();
        check("wake_flush_q4", {25'd0, strb()}, 32'd0);
        step();
        check("wake_ir", {20'd0, ir_reg_bus}, 32'h1C0);
        check("wake_pc_inc", {25'd0, strb()}, {25'd0, S_INC});

        run_row(18, '{12'h1E5, 1'b0, S_INC, 2'd0, 7'b1010000});

        step();
        step();
        step();
        check("pre_rst_strobes", {25'd0, strb()}, 32'b0110000);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", {25'd0, strb()}, 32'd0);
        check("midrst_ir_phase", {18'd0, ir_reg_bus, q_phase}, 32'd0);
        step();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pic10_control.md
Name: pic10_control

Overview:
- Instruction sequencer for the PIC10 core. Generates the 4-clock Q-cycle, latches fetched instruction words into the instruction register, decodes them, and drives ALU operand select, W/file/STATUS write strobes and program-counter/stack commands.
- Owns ir_reg_bus, the opcode input of pic10_alu. Handles two-cycle instructions (GOTO, CALL, RETLW), conditional skips and SLEEP.

Parameters:
- RESET_FLUSH, 1, when 1 the first instruction cycle after reset is a flush (NOP) cycle while word 0 is fetched.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- prog_data  in  12  instruction word from program memory at current PC
- alu_zero  in  1  ALU result-is-zero, valid in Q3/Q4
- wake  in  1  wake request in SLEEP (level)
- ir_reg_bus  out  12  instruction register, drives pic10_alu opcode
- q_phase  out  2  0=Q1, 1=Q2, 2=Q3, 3=Q4
- alu_mux_sel  out  2  0=file reg, 1=literal k (ir[7:0]), 2=bit mask from ir[7:5]
- w_we  out  1  W write strobe
- f_we  out  1  file-register write strobe
- status_we  out  1  STATUS flag write strobe
- pc_inc  out  1  PC increment strobe
- pc_load  out  1  load PC from ir (GOTO ir[8:0], CALL ir[7:0])
- stack_push  out  1  push PC+1 (CALL)
- stack_pop  out  1  pop PC (RETLW)
- sleeping  out  1  block is in SLEEP

Behaviour:
- Reset (async, rst_n=0): ir_reg_bus=12'h000, q_phase=0, all strobes 0, sleeping=0, alu_mux_sel=0. State goes to FLUSH if RESET_FLUSH=1, otherwise to EXEC.
- q_phase increments every clk, 3 wraps to 0. It is frozen at 0 in SLEEP.
- States:
  - EXEC: normal execution.
  - FLUSH: the instruction in ir is discarded; no w_we, f_we, status_we, pc_load or stack commands are issued.
  - SLEEP: clock-gated behaviour.
- Per instruction cycle in EXEC or FLUSH:
  - Q1: pc_inc=1 for one clk.
  - Q2: alu_mux_sel valid, held through Q4.
  - Q4: all write and PC-control strobes pulse for one clk; ir_reg_bus <= prog_data on the Q4 rising edge.
- Decode (opcode = ir[11:6] unless noted; d=ir[5]):
  - d=0 writes W, d=1 writes f, for SUBWF/DECF/IORWF/ANDWF/XORWF/ADDWF/MOVF/COMF/INCF/RRF/RLF/SWAPF/DECFSZ/INCFSZ.
  - MOVWF (ir[11:5]=0000001): f_we.
  - CLRF/CLRW: f_we or w_we respectively, plus status_we.
  - status_we on the arithmetic/logic ops that affect flags.
  - Literal ops MOVLW/IORLW/ANDLW/XORLW (ir[11:8]=1100..1111): alu_mux_sel=1, w_we.
  - RETLW (1000): alu_mux_sel=1, w_we, stack_pop, pc_load-from-stack.
  - BCF/BSF (010x): alu_mux_sel=2, f_we.
  - BTFSC/BTFSS (011x): alu_mux_sel=2, no write.
- Two-cycle instructions:
  - GOTO (101x): pc_load at Q4, next state FLUSH.
  - CALL (1001): stack_push + pc_load at Q4, next state FLUSH.
  - RETLW: next state FLUSH.
- Skips: DECFSZ/INCFSZ/BTFSC skip when alu_zero=1 at Q4; BTFSS skips when alu_zero=0. A skip makes the next state FLUSH. The writeback of DECFSZ/INCFSZ still occurs.
- FLUSH lasts exactly one instruction cycle, then EXEC. A flush instruction cannot itself branch or skip.
- SLEEP (ir=12'h003): at Q4 the next state is SLEEP, sleeping=1, no strobes.
  - wake=1 sampled at any clk: next state FLUSH with q_phase=1.
  - PC does not advance during SLEEP.
- NOP, CLRWDT, OPTION, TRIS: no strobes other than pc_inc.
- Reset asserted mid-cycle aborts immediately; no partial strobe is emitted.

Optional Feature:
- Macro PIC10_CTRL_ILLEGAL_TRAP_EN.
- Defined: any opcode outside the baseline set (e.g. 12'h001, 12'h005, 12'h008–12'h01F) enters TRAP state at Q4. TRAP drives a sticky output illegal_op=1, freezes q_phase at 0 and issues no strobes until reset.
- Undefined: there is no illegal_op port, and illegal opcodes execute as NOP.

Decomposition:
- Package pic10_pkg: opcode constants, state enum (EXEC, FLUSH, SLEEP, TRAP), alu_mux_sel encodings, Q-phase constants.
- Sub-module pic10_decode: purely combinational ir -> {alu_mux_sel, w_wr, f_wr, st_wr, is_goto, is_call, is_retlw, skip_type, is_sleep, illegal}.
- pic10_control holds the phase counter, state register, ir and the strobe timing.

Test Plan:
- Reset release with RESET_FLUSH=1, prog_data=12'h1C0 -> first cycle has no w_we; ir=12'h1C0 after the first Q4; next cycle Q4 gives w_we=1, f_we=0, status_we=1.
- ir=12'h1E5 (ADDWF f=5, d=1) -> Q4: f_we=1, w_we=0, status_we=1, alu_mux_sel=0 from Q2.
- ir=12'hA10 (GOTO 0x010) -> Q4: pc_load=1; following cycle is FLUSH with no strobes except pc_inc.
- ir=12'h2C3 (DECFSZ) with alu_zero=1 at Q4 -> writeback pulse plus next cycle FLUSH; repeat with alu_zero=0 -> no flush.
- ir=12'h003 (SLEEP) -> sleeping=1 and q_phase stuck at 0 for 20 clks; wake=1 -> FLUSH then resume EXEC.
- With PIC10_CTRL_ILLEGAL_TRAP_EN, ir=12'h001 -> illegal_op=1 stays high and strobes stay 0 until rst_n=0.
